// File: rtl/spi_slave_frame_if.sv
// rtl/spi_slave_frame_if.sv - SPI pins plus RAM-side rx/tx handshake bundle for spi_slave_frame.
interface spi_slave_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sclk;
    logic                  ss_n;
    logic                  mosi;
    logic                  miso;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_underrun;
    logic [DATA_WIDTH+1:0] rx_data;
    logic                  rx_valid;

    modport master (
        output sclk, ss_n, mosi, tx_data, tx_valid,
        input  miso, tx_ready, tx_underrun, rx_data, rx_valid
    );

    modport slave (
        input  sclk, ss_n, mosi, tx_data, tx_valid,
        output miso, tx_ready, tx_underrun, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_frame.sv
// rtl/spi_slave_frame.sv - oversampled SPI slave: {cmd,payload} receive, read-data return, all four modes.
// Optional back-to-back frames per SS_n window: define SPI_SLAVE_BURST_EN.
module spi_slave_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    spi_slave_frame_if.slave bus
);
    localparam int   FW  = DATA_WIDTH + 2;
    localparam int   CW  = $clog2(FW);
    localparam logic POL = (CPOL != 0);
    localparam logic PHA = (CPHA != 0);

    typedef enum logic [2:0] {S_IDLE, S_RX, S_WAIT_TX, S_TX, S_DONE} state_t;

    logic [1:0]    sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic          sclk_dly_q, ss_dly_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] shreg_q, shreg_d;
    logic          skip_q, skip_d;
    logic          miso_q, miso_d;
    logic [FW-1:0] rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          underrun_q, underrun_d;

    logic sclk_s, ss_s, mosi_s, ss_fall, lead_e, trail_e, sample_e, launch_e;

    assign sclk_s   = sclk_sync_q[1];
    assign ss_s     = ss_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign ss_fall  = !ss_s && ss_dly_q;
    assign lead_e   = (sclk_s != POL) && (sclk_dly_q == POL);
    assign trail_e  = (sclk_s == POL) && (sclk_dly_q != POL);
    assign sample_e = PHA ? trail_e : lead_e;
    assign launch_e = PHA ? lead_e : trail_e;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        skip_d     = skip_q;
        miso_d     = miso_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = underrun_q;
        if (ss_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ss_fall) begin
                        state_d    = S_RX;
                        cnt_d      = CW'(FW - 1);
                        shreg_d    = '0;
                        underrun_d = 1'b0;
                    end
                end
                S_RX: begin
                    if (sample_e) begin
                        shreg_d = {shreg_q[FW-2:0], mosi_s};
                        if (cnt_q == '0) begin
                            rx_data_d  = shreg_d;
                            rx_valid_d = 1'b1;
                            state_d    = (shreg_d[FW-1:FW-2] == 2'b11) ? S_WAIT_TX : S_DONE;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                S_WAIT_TX: begin
                    if (bus.tx_valid) begin
                        shreg_d = {2'b00, bus.tx_data};
                        miso_d  = bus.tx_data[DATA_WIDTH-1];
                        cnt_d   = CW'(DATA_WIDTH - 1);
                        skip_d  = 1'b1;
                        state_d = S_TX;
                    end else if (lead_e) begin
                        // The first leading edge is a launch (CPHA=1) or a sample (CPHA=0); either way no data arrived in time.
                        underrun_d = 1'b1;
                        miso_d     = 1'b0;
                        shreg_d    = '0;
                        skip_d     = 1'b0;
                        cnt_d      = PHA ? CW'(DATA_WIDTH - 1) : CW'(DATA_WIDTH - 2);
                        state_d    = S_TX;
                    end
                end
                S_TX: begin
                    // MSB is already on MISO at load; launch edges before the first sample must not shift it away.
                    if (launch_e && !skip_q) begin
                        shreg_d = shreg_q << 1;
                        miso_d  = shreg_q[DATA_WIDTH-2];
                    end
                    if (sample_e) begin
                        skip_d = 1'b0;
                        if (cnt_q == '0) begin
                            state_d = S_DONE;
                            miso_d  = 1'b0;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    miso_d = 1'b0;
`ifdef SPI_SLAVE_BURST_EN
                    state_d = S_RX;
                    cnt_d   = CW'(FW - 1);
                    shreg_d = '0;
`else
                    state_d = S_DONE;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= {2{POL}};
            sclk_dly_q  <= POL;
            ss_sync_q   <= 2'b11;
            ss_dly_q    <= 1'b1;
            mosi_sync_q <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            skip_q      <= 1'b0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], bus.sclk};
            sclk_dly_q  <= sclk_sync_q[1];
            ss_sync_q   <= {ss_sync_q[0], bus.ss_n};
            ss_dly_q    <= ss_sync_q[1];
            mosi_sync_q <= {mosi_sync_q[0], bus.mosi};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            skip_q      <= skip_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign bus.miso        = miso_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_ready    = (state_q == S_WAIT_TX);
    assign bus.tx_underrun = underrun_q;
endmodule

// File: tb/tb_spi_slave_frame.sv
// tb/tb_spi_slave_frame.sv - bench driving one spi_slave_frame per SPI mode from a master-side frame model.
module tb_spi_slave_frame;
    localparam int DW = 8;
    localparam int H  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]    sclk_v, ss_v, mosi_v, txv_v;
    logic [DW-1:0] txd;
    wire  [3:0]    miso_w, rxv_w, rdy_w, urun_w;
    wire  [DW+1:0] rxd_w [4];

    for (genvar m = 0; m < 4; m++) begin : g_mode
        spi_slave_frame_if #(.DATA_WIDTH(DW)) bus ();
        assign bus.sclk     = sclk_v[m];
        assign bus.ss_n     = ss_v[m];
        assign bus.mosi     = mosi_v[m];
        assign bus.tx_valid = txv_v[m];
        assign bus.tx_data  = txd;
        assign miso_w[m]    = bus.miso;
        assign rxv_w[m]     = bus.rx_valid;
        assign rdy_w[m]     = bus.tx_ready;
        assign urun_w[m]    = bus.tx_underrun;
        assign rxd_w[m]     = bus.rx_data;
        spi_slave_frame #(.DATA_WIDTH(DW), .CPOL(m / 2), .CPHA(m % 2)) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus.slave)
        );
    end

    int            checks = 0;
    int            failures = 0;
    int            act = 0;
    bit            supply, given, ready_seen, miso_hi;
    logic [DW+1:0] rx_q [$];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rxv_w[act]) rx_q.push_back(rxd_w[act]);
            if (miso_w[act]) miso_hi = 1'b1;
            if (txv_v[act]) begin
                txv_v[act] = 1'b0;
                given = 1'b1;
            end else if (supply && !given && rdy_w[act]) begin
                if (ready_seen) txv_v[act] = 1'b1;
                else ready_seen = 1'b1;
            end
        end
    endtask

    task automatic ss_low(input int md);
        act = md;
        rx_q.delete();
        given = 1'b0;
        ready_seen = 1'b0;
        miso_hi = 1'b0;
        ss_v[md] = 1'b0;
        tick(H);
    endtask

    task automatic ss_high(input int md);
        ss_v[md] = 1'b1;
        tick(H);
    endtask

    // Master side: drives nbits SCLK cycles; bits past the 10-bit header are read data captured at sample edges.
    task automatic run_frame(input int md, input logic [DW+1:0] frame, input int nbits, output logic [DW-1:0] cap);
        logic pol, pha, b;
        pol = (md >= 2);
        pha = (md % 2 == 1);
        cap = '0;
        for (int k = 0; k < nbits; k++) begin
            b = (k < DW + 2) ? frame[DW+1-k] : 1'b0;
            if (!pha) begin
                mosi_v[md] = b;
                tick(H);
                if (k >= DW + 2) cap[2*DW+1-k] = miso_w[md];
                sclk_v[md] = ~pol;
                tick(H);
                sclk_v[md] = pol;
            end else begin
                sclk_v[md] = ~pol;
                mosi_v[md] = b;
                tick(H);
                if (k >= DW + 2) cap[2*DW+1-k] = miso_w[md];
                sclk_v[md] = pol;
                tick(H);
            end
        end
        tick(H);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ss_v = 4'hF; sclk_v = 4'b1100; mosi_v = 4'h0; txv_v = 4'h0; txd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            checks++;
            if ({miso_w[m], rxv_w[m], rdy_w[m], urun_w[m], rxd_w[m]} !== '0)
                begin failures++; $display("FAIL reset_state mode%0d got=%b req=0", m, {miso_w[m], rxv_w[m], rdy_w[m], urun_w[m], rxd_w[m]}); end
        end
    endtask

    task automatic test_mode0_write();
        logic [DW-1:0] cap;
        ss_low(0);
        run_frame(0, 10'h0A5, 10, cap);
        checks++;
        if (rx_q.size() != 1) begin failures++; $display("FAIL m0_write_pulses got=%0d req=1", rx_q.size()); end
        checks++;
        if (rx_q.size() == 0 || rx_q[0] !== 10'h0A5) begin failures++; $display("FAIL m0_write_data got=%h req=0a5", rxd_w[0]); end
        checks++;
        if (miso_hi !== 1'b0) begin failures++; $display("FAIL m0_write_miso got=1 req=0"); end
        ss_high(0);
        checks++;
        if (rxd_w[0] !== 10'h0A5) begin failures++; $display("FAIL m0_rx_hold got=%h req=0a5", rxd_w[0]); end
    endtask

    task automatic test_mode3_read();
        logic [DW-1:0] cap;
        supply = 1'b1;
        txd = 8'hC3;
        ss_low(3);
        run_frame(3, 10'h300, 18, cap);
        checks++;
        if (cap !== 8'hC3) begin failures++; $display("FAIL m3_read_miso got=%h req=c3", cap); end
        checks++;
        if (urun_w[3] !== 1'b0) begin failures++; $display("FAIL m3_read_underrun got=%b req=0", urun_w[3]); end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 10'h300) begin failures++; $display("FAIL m3_read_rx got_n=%0d got=%h req=300", rx_q.size(), rxd_w[3]); end
        checks++;
        if (given !== 1'b1 || rdy_w[3] !== 1'b0) begin failures++; $display("FAIL m3_read_handshake given=%b ready=%b req=1,0", given, rdy_w[3]); end
        ss_high(3);
    endtask

    task automatic test_underrun();
        logic [DW-1:0] cap;
        supply = 1'b0;
        ss_low(1);
        run_frame(1, 10'h3A6, 18, cap);
        checks++;
        if (cap !== 8'h00 || miso_hi !== 1'b0) begin failures++; $display("FAIL underrun_miso got=%h req=00", cap); end
        checks++;
        if (urun_w[1] !== 1'b1) begin failures++; $display("FAIL underrun_set got=%b req=1", urun_w[1]); end
        ss_high(1);
        checks++;
        if (urun_w[1] !== 1'b1) begin failures++; $display("FAIL underrun_sticky got=%b req=1", urun_w[1]); end
        ss_low(1);
        checks++;
        if (urun_w[1] !== 1'b0) begin failures++; $display("FAIL underrun_clear got=%b req=0", urun_w[1]); end
        ss_high(1);
    endtask

    task automatic test_partial();
        logic [DW-1:0] cap;
        supply = 1'b0;
        ss_low(2);
        run_frame(2, 10'h2C7, 10, cap);
        ss_high(2);
        ss_low(2);
        run_frame(2, 10'h13C, 5, cap);
        ss_high(2);
        checks++;
        if (rx_q.size() != 0 || rxd_w[2] !== 10'h2C7) begin failures++; $display("FAIL partial_discard got_n=%0d got=%h req=0,2c7", rx_q.size(), rxd_w[2]); end
        ss_low(2);
        run_frame(2, 10'h13C, 10, cap);
        checks++;
        if (rx_q.size() != 1 || rxd_w[2] !== 10'h13C) begin failures++; $display("FAIL partial_recover got_n=%0d got=%h req=1,13c", rx_q.size(), rxd_w[2]); end
        ss_high(2);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] cap;
        logic [DW+1:0] exp_q [$];
        exp_q = {10'h1FF};
`ifdef SPI_SLAVE_BURST_EN
        exp_q.push_back(10'h155);
`endif
        supply = 1'b0;
        ss_low(0);
        run_frame(0, 10'h1FF, 10, cap);
        run_frame(0, 10'h155, 10, cap);
        ss_high(0);
        checks++;
        if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL burst_count got=%0d req=%0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL burst_word%0d got=%h req=%h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [DW-1:0] cap;
        supply = 1'b0;
        ss_low(3);
        run_frame(3, 10'h35A, 13, cap);
        checks++;
        if (urun_w[3] !== 1'b1 || rxd_w[3] !== 10'h35A) begin failures++; $display("FAIL midtx_pre got=%b,%h req=1,35a", urun_w[3], rxd_w[3]); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({miso_w[3], rxv_w[3], rdy_w[3], urun_w[3], rxd_w[3]} !== '0)
            begin failures++; $display("FAIL midtx_reset got=%b req=0", {miso_w[3], rxv_w[3], rdy_w[3], urun_w[3], rxd_w[3]}); end
        rst = 1'b0;
        ss_high(3);
    endtask

    task automatic test_random();
        logic [DW-1:0] cap, exp_cap;
        logic [DW+1:0] frame;
        int md;
        bit rd;
        for (int it = 0; it < 12; it++) begin
            md     = $urandom_range(0, 3);
            frame  = 10'($urandom);
            txd    = 8'($urandom);
            supply = ($urandom_range(0, 1) == 1);
            rd     = (frame[DW+1:DW] == 2'b11);
            exp_cap = supply ? txd : 8'h00;
            ss_low(md);
            run_frame(md, frame, rd ? DW + 10 : 10, cap);
            checks++;
            if (rx_q.size() != 1 || rx_q[0] !== frame) begin failures++; $display("FAIL rand%0d_rx mode%0d got_n=%0d got=%h req=%h", it, md, rx_q.size(), rxd_w[md], frame); end
            checks++;
            if (rdy_w[md] !== 1'b0) begin failures++; $display("FAIL rand%0d_ready got=1 req=0", it); end
            if (rd) begin
                checks++;
                if (cap !== exp_cap) begin failures++; $display("FAIL rand%0d_miso mode%0d got=%h req=%h", it, md, cap, exp_cap); end
                checks++;
                if (urun_w[md] !== !supply) begin failures++; $display("FAIL rand%0d_underrun got=%b req=%b", it, urun_w[md], !supply); end
            end else begin
                checks++;
                if (miso_hi !== 1'b0 || urun_w[md] !== 1'b0) begin failures++; $display("FAIL rand%0d_write_idle miso=%b urun=%b req=0,0", it, miso_hi, urun_w[md]); end
            end
            ss_high(md);
        end
    endtask

    initial begin
        supply = 1'b0;
        test_reset();
        test_mode0_write();
        test_mode3_read();
        test_underrun();
        test_partial();
        test_back_to_back();
        test_reset_mid_tx();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave_frame.md
# spi_slave_frame

Parametrised SPI slave frame engine, the successor to the fixed 10-bit-in / 8-bit-out slave. It recovers an externally generated SCLK by oversampling on the system clock and supports all four SPI modes. It decodes a 2-bit command prefix with a DATA_WIDTH payload and hands words to the RAM-side logic over a valid pulse. Read data is returned over a tx_valid handshake with underrun detection.

## Interface
- DATA_WIDTH, 8: payload bits per frame; rx_data is DATA_WIDTH+2 wide.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- CLK  input  1  system clock; must be at least 4x SCLK frequency.
- rst  input  1  synchronous, active-high reset.
- SCLK  input  1  SPI clock, asynchronous to CLK.
- SS_n  input  1  active-low chip select, asynchronous.
- MOSI  input  1  master-out data, MSB first.
- tx_data  input  DATA_WIDTH  read data from the RAM side.
- tx_valid  input  1  tx_data valid; consumed in WAIT_TX only.
- MISO  output  1  slave-out data, MSB first.
- rx_data  output  DATA_WIDTH+2  received {cmd[1:0], payload}.
- rx_valid  output  1  one-CLK pulse when rx_data updates.
- tx_ready  output  1  high in WAIT_TX; a transfer occurs when tx_ready && tx_valid.
- tx_underrun  output  1  sticky; set when a TX launch edge occurs with no word loaded; cleared by reset or SS_n falling.

## Operation
- Sync path: SCLK, SS_n and MOSI each pass through 2-flop synchronisers. Edges are detected from the synchronised SCLK and a delayed copy.
- Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
- Sample edge = leading if CPHA=0, otherwise trailing. Launch edge = the opposite edge.
- Command field rx_data[DATA_WIDTH+1:DATA_WIDTH]: 00 write addr, 01 write data, 10 read addr, 11 read data.
- States:
  - IDLE: SS_n high. SS_n falling moves to RX, bit counter = DATA_WIDTH+1, tx_underrun cleared.
  - RX: shift MOSI into a shift register on each sample edge. On the final bit, load rx_data and pulse rx_valid the next CLK. If cmd = 11, go to WAIT_TX; otherwise go to DONE.
  - WAIT_TX: tx_ready = 1. On tx_valid, load the shift register with tx_data, drive MISO = tx_data[DATA_WIDTH-1] and go to TX. If a launch edge arrives first (CPHA=1) or a sample edge arrives first (CPHA=0), set tx_underrun, drive MISO = 0 and go to TX with a zero shift register.
  - TX: shift the next bit onto MISO on each launch edge. For CPHA=1, the first leading edge in TX does not shift. After DATA_WIDTH sample edges, go to DONE.
  - DONE: ignore SCLK; MISO = 0. Without the burst macro, leave only via SS_n high.
- SS_n rising (synchronised) in any state moves to IDLE next CLK: counter reset, MISO = 0, partial frame discarded, no rx_valid.
- rx_data holds its last value between frames.
- rst has priority over all events.

## Timing
- Reset values: MISO 0, rx_data 0, rx_valid 0, tx_ready 0, tx_underrun 0, state IDLE.
- Input latency: SCLK/SS_n edge to internal action is 3 CLK (2 synchroniser stages + 1 edge-detect stage).
- rx_valid asserts 1 CLK after the final-bit sample edge is detected and lasts exactly 1 CLK.
- tx_ready rises the same CLK as rx_valid for cmd 11. It falls the CLK after tx_valid is accepted.
- MISO changes at most once per launch edge. It is registered and stable for at least 1 SCLK half-period before the master samples.
- Simultaneous SS_n rise and final sample edge: SS_n wins and no rx_valid is issued.

## Configuration
- SPI_SLAVE_BURST_EN defined: DONE with SS_n still low re-arms RX (counter = DATA_WIDTH+1) on the next CLK, so back-to-back frames within one SS_n window each produce an rx_valid. tx_underrun stays sticky across frames in the window.
- Undefined: exactly one frame per SS_n assertion. Extra SCLK edges are ignored until SS_n goes high.

## Test plan
- Mode 0, DATA_WIDTH=8: SS_n low, shift 10'b00_1010_0101 -> rx_data = 10'h0A5, one rx_valid pulse, MISO stays 0.
- Mode 3: frame 10'b11_0000_0000, tx_valid with tx_data = 8'hC3 one CLK after tx_ready -> MISO sequence 1,1,0,0,0,0,1,1 on the sample edges, tx_underrun = 0.
- Read data with tx_valid withheld -> tx_underrun = 1, MISO = 0 for all 8 bits, reset to 0 on the next SS_n fall.
- SS_n raised after 5 bits -> no rx_valid, rx_data unchanged, state IDLE; the next full frame decodes correctly.
- With SPI_SLAVE_BURST_EN: two frames 10'h1FF and 10'h155 in one SS_n window -> two rx_valid pulses with those values. Without the macro: only 10'h1FF.
- rst asserted mid-TX -> all outputs reach their reset values on the next CLK edge.
